// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic unit.
//   - div_state_e : sequential divider control states
//   - DIV_W       : operand width of the divider / adder_subtractor datapath
//   - DIV_ITER    : number of restoring iterations per division
//   - DIV_CNT_W   : width of the iteration counter
package arith_pkg;

    localparam int unsigned DIV_W     = 4;
    localparam int unsigned DIV_ITER  = 4;
    localparam int unsigned DIV_CNT_W = 3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } div_state_e;

    // Restoring step input: the partial remainder shifted left by one with the
    // next dividend bit brought in. Bit DIV_W is the bit shifted out of A.
    function automatic logic [DIV_W:0] div_shift_pair(input logic [DIV_W-1:0] a,
                                                      input logic             q_msb);
        return {a, q_msb};
    endfunction

endpackage

// File: rtl/adder_subtractor.sv
// Combinational 4-bit ripple-carry adder/subtractor.
//   a, b : operands
//   m    : mode, 0 = a + b, 1 = a - b (two's complement, b inverted, carry-in 1)
//   s    : sum / difference
//   cout : carry out; in subtract mode 1 means no borrow (a >= b)
module adder_subtractor
    import arith_pkg::*;
(
    input  logic [DIV_W-1:0] a,
    input  logic [DIV_W-1:0] b,
    input  logic             m,
    output logic [DIV_W-1:0] s,
    output logic             cout
);

    logic [DIV_W-1:0] b_eff;
    logic [DIV_W:0]   carry;

    assign b_eff    = b ^ {DIV_W{m}};
    assign carry[0] = m;

    for (genvar i = 0; i < DIV_W; i++) begin : g_fa
        assign s[i]       = a[i] ^ b_eff[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b_eff[i]) | (a[i] & carry[i]) | (b_eff[i] & carry[i]);
    end

    assign cout = carry[DIV_W];

endmodule

// File: rtl/seq_divider.sv
// Sequential 4-bit unsigned restoring divider, one iteration per clock.
//   clk         : clock, rising edge
//   rst_n       : synchronous active-low reset
//   start       : request a division, only honoured in idle
//   dividend    : unsigned dividend, captured with an accepted start
//   divisor     : unsigned divisor, captured with an accepted start
//   busy        : division in progress
//   done        : one-cycle pulse when results become valid
//   quotient    : registered quotient, held until the next accepted start
//   remainder   : registered remainder, held until the next accepted start
//   div_by_zero : divisor was zero; quotient forced to all ones, remainder = dividend
module seq_divider
    import arith_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    input  logic [DIV_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DIV_W-1:0] quotient,
    output logic [DIV_W-1:0] remainder,
    output logic             div_by_zero
);

    div_state_e state_q, state_d;

    logic [DIV_W-1:0]     a_q, a_d;
    logic [DIV_W-1:0]     q_q, q_d;
    logic [DIV_W-1:0]     m_q, m_d;
    logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0]     quotient_q, quotient_d;
    logic [DIV_W-1:0]     remainder_q, remainder_d;
    logic                 dbz_q, dbz_d;

    // Trial subtraction datapath
    logic [DIV_W:0]   shift_pair;
    logic             shift_msb;
    logic [DIV_W-1:0] a_shift;
    logic [DIV_W-1:0] diff;
    logic             no_borrow;
    logic             q_bit;

    assign shift_pair = div_shift_pair(a_q, q_q[DIV_W-1]);
    assign shift_msb  = shift_pair[DIV_W];
    assign a_shift    = shift_pair[DIV_W-1:0];

    adder_subtractor u_addsub (
        .a    (a_shift),
        .b    (m_q),
        .m    (1'b1),
        .s    (diff),
        .cout (no_borrow)
    );

    // A set shifted-out bit means the true shifted remainder is >= 16 > M, so the
    // subtraction must succeed; the 4-bit difference is still exact because
    // A < M keeps the true difference below M.
    assign q_bit = shift_msb | no_borrow;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        q_d         = q_q;
        m_d         = m_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    a_d         = '0;
                    q_d         = dividend;
                    m_d         = divisor;
                    cnt_d       = DIV_CNT_W'(DIV_ITER);
                    quotient_d  = '0;
                    remainder_d = '0;
                    dbz_d       = 1'b0;
                    if (divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        state_d     = StDone;
                    end else begin
                        state_d = StCalc;
                    end
                end
            end

            StCalc: begin
                a_d   = q_bit ? diff : a_shift;
                q_d   = {q_q[DIV_W-2:0], q_bit};
                cnt_d = cnt_q - DIV_CNT_W'(1);
                if (cnt_q == DIV_CNT_W'(1)) begin
                    // Last iteration: publish the post-update registers.
                    quotient_d  = q_d;
                    remainder_d = a_d;
                    state_d     = StDone;
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            a_q         <= '0;
            q_q         <= '0;
            m_q         <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            q_q         <= q_d;
            m_q         <= m_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = (state_q == StCalc);
    assign done        = (state_q == StDone);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
